// File: rtl/replay_buffer_demux_nway.sv
// Replay buffer that demultiplexes Q time-multiplexed spike wires into
// N_NET per-network streams. One bank is written at N_NET-fold time expansion
// while the other bank is replayed; the banks swap on every gamma wrap.
module replay_buffer_demux_nway #(
  parameter int unsigned Q                  = 2,
  parameter int unsigned N_NET              = 2,
  parameter int unsigned GAMMA_CYCLE_LENGTH = 18,
  localparam int unsigned CW                = $clog2(GAMMA_CYCLE_LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_count,
  input  logic [Q-1:0]                muxed_output_spikes,
  input  logic [N_NET-1:0]            net_en,
  output logic [Q-1:0][N_NET-1:0]     demuxed_output_spikes,
  output logic [CW-1:0]               cycle_counter,
  output logic                        bank_sel,
  output logic                        gamma_wrap,
  output logic                        out_valid
);

  localparam int unsigned G  = GAMMA_CYCLE_LENGTH;
  localparam int unsigned S  = G / N_NET;
  localparam int unsigned IW = CW + 1;

  logic [G-1:0]             bank_q [2][Q][N_NET];
  logic [G-1:0]             bank_d [2][Q][N_NET];
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     bank_sel_q, bank_sel_d;
  logic                     wrap_q, wrap_d;
  logic                     valid_q, valid_d;
  logic                     run_q, run_d;
  logic [N_NET-1:0]         en_q, en_d;
  logic [Q-1:0][N_NET-1:0]  demux_q, demux_d;

  logic [IW-1:0]            c_ext;
  logic [IW-1:0]            net_idx;
  logic [IW-1:0]            pos;
  logic [IW-1:0]            base;
  logic [N_NET-1:0]         en_eff;
  logic                     last;

  // Next-state: counter/bank sequencing, expanded bank write, replay read
  always_comb begin
    cnt_d      = cnt_q;
    bank_sel_d = bank_sel_q;
    wrap_d     = 1'b0;
    valid_d    = valid_q;
    run_d      = run_q;
    en_d       = en_q;
    demux_d    = '0;
    bank_d     = bank_q;
    c_ext      = IW'(cnt_q);
    net_idx    = c_ext / IW'(S);
    pos        = c_ext % IW'(S);
    base       = pos * IW'(N_NET);
    // the first running edge after a clear uses the live enable it is sampling
    en_eff     = run_q ? en_q : net_en;
    last       = (cnt_q == CW'(G - 1));

    if (!start_count) begin
      cnt_d      = '0;
      bank_sel_d = 1'b0;
      valid_d    = 1'b0;
      run_d      = 1'b0;
      en_d       = '0;
      bank_d     = '{default: '0};
    end else begin
      run_d = 1'b1;
      if (!run_q || last) begin
        en_d = net_en;
      end

      for (int unsigned q = 0; q < Q; q++) begin
        for (int unsigned m = 0; m < N_NET; m++) begin
          for (int unsigned j = 0; j < G; j++) begin
            if (en_eff[m] && (net_idx == IW'(m)) &&
                (IW'(j) >= base) && (IW'(j) < base + IW'(N_NET))) begin
              bank_d[bank_sel_q][q][m][j] = muxed_output_spikes[q];
            end
          end
          demux_d[q][m] = valid_q & en_eff[m] & bank_q[~bank_sel_q][q][m][cnt_q];
        end
      end

      cnt_d      = last ? '0 : cnt_q + CW'(1);
      bank_sel_d = last ? ~bank_sel_q : bank_sel_q;
      valid_d    = valid_q | last;
      wrap_d     = (cnt_d == CW'(G - 1));
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bank_sel_q <= 1'b0;
      wrap_q     <= 1'b0;
      valid_q    <= 1'b0;
      run_q      <= 1'b0;
      en_q       <= '0;
      demux_q    <= '0;
      bank_q     <= '{default: '0};
    end else begin
      cnt_q      <= cnt_d;
      bank_sel_q <= bank_sel_d;
      wrap_q     <= wrap_d;
      valid_q    <= valid_d;
      run_q      <= run_d;
      en_q       <= en_d;
      demux_q    <= demux_d;
      bank_q     <= bank_d;
    end
  end

  assign demuxed_output_spikes = demux_q;
  assign cycle_counter         = cnt_q;
  assign bank_sel              = bank_sel_q;
  assign gamma_wrap            = wrap_q;
  assign out_valid             = valid_q;

endmodule

// File: tb/tb_replay_buffer_demux_nway.sv
// Self-checking bench for replay_buffer_demux_nway: directed scenarios plus
// randomized traffic against a per-gamma history model.
module tb_replay_buffer_demux_nway;

  localparam int unsigned Q    = 2;
  localparam int unsigned N    = 2;
  localparam int unsigned G    = 18;
  localparam int unsigned S    = G / N;
  localparam int unsigned MAXG = 64;

  logic clk = 1'b0;
  logic rst;
  logic start_count;
  logic [Q-1:0]        muxed;
  logic [N-1:0]        net_en;
  logic [2:0]          net_en3;
  logic [Q-1:0][N-1:0] dem;
  logic [4:0]          cnt;
  logic                bsel, wrap, valid;
  logic [Q-1:0][2:0]   dem3;
  logic [4:0]          cnt3;
  logic                bsel3, wrap3, valid3;

  always #5 clk = ~clk;

  replay_buffer_demux_nway #(.Q(Q), .N_NET(N), .GAMMA_CYCLE_LENGTH(G)) u_dut (
    .clk(clk), .rst(rst), .start_count(start_count),
    .muxed_output_spikes(muxed), .net_en(net_en),
    .demuxed_output_spikes(dem), .cycle_counter(cnt), .bank_sel(bsel),
    .gamma_wrap(wrap), .out_valid(valid)
  );

  replay_buffer_demux_nway #(.Q(Q), .N_NET(3), .GAMMA_CYCLE_LENGTH(G)) u_dut3 (
    .clk(clk), .rst(rst), .start_count(start_count),
    .muxed_output_spikes(muxed), .net_en(net_en3),
    .demuxed_output_spikes(dem3), .cycle_counter(cnt3), .bank_sel(bsel3),
    .gamma_wrap(wrap3), .out_valid(valid3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: inputs recorded per gamma, outputs derived from history
  int                  m_c, m_g, t_rel;
  bit                  m_run;
  logic [Q-1:0]        hist [MAXG][G];
  logic [N-1:0]        en_g [MAXG];
  logic [Q-1:0][N-1:0] exp_dem;

  // Replayed bit: latest earlier same-parity gamma whose network was enabled
  function automatic logic data_of(int g, int m, int q, int j);
    for (int h = g - 1; h >= 0; h -= 2) begin
      if (en_g[h][m]) return hist[h][m * S + j / N][q];
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_run   = 1'b0;
    m_c     = 0;
    m_g     = 0;
    t_rel   = 0;
    exp_dem = '0;
  endtask

  // Advance the model with the current inputs, then clock the DUT
  task automatic step();
    if (m_g >= int'(MAXG) - 1) begin
      $display("FAIL model_range g=%0d limit=%0d", m_g, MAXG);
      $fatal(1);
    end
    if (!start_count) begin
      model_clear();
    end else begin
      if (!m_run) begin
        en_g[0] = net_en;
        m_run   = 1'b1;
      end
      for (int q = 0; q < int'(Q); q++)
        for (int m = 0; m < int'(N); m++)
          exp_dem[q][m] = (m_g >= 1) && en_g[m_g][m] && data_of(m_g, m, q, m_c);
      hist[m_g][m_c] = muxed;
      if (m_c == int'(G) - 1) begin
        m_c = 0;
        m_g++;
        en_g[m_g] = net_en;
      end else begin
        m_c++;
      end
      t_rel++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    start_count = 1'b0;
    muxed       = '0;
    step();
    start_count = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_count = 1'b0; muxed = '0; net_en = '0; net_en3 = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({dem, cnt, bsel, wrap, valid} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", {dem, cnt, bsel, wrap, valid});
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_run_from_start();
    do_clear();
    net_en = 2'b11;
    for (int t = 0; t < 3 * int'(G); t++) begin
      muxed = Q'($urandom);
      step();
      checks++;
      if (valid !== (t_rel >= int'(G))) begin
        errors++; $display("FAIL run_valid t=%0d got=%b want=%b", t_rel, valid, t_rel >= int'(G));
      end
      checks++;
      if (cnt !== 5'(t_rel % int'(G))) begin
        errors++; $display("FAIL run_counter t=%0d got=%0d want=%0d", t_rel, cnt, t_rel % int'(G));
      end
      checks++;
      if (wrap !== ((t_rel % int'(G)) == int'(G) - 1)) begin
        errors++; $display("FAIL run_wrap t=%0d got=%b", t_rel, wrap);
      end
      checks++;
      if (bsel !== 1'((t_rel / int'(G)) % 2)) begin
        errors++; $display("FAIL run_bank_sel t=%0d got=%b want=%0d", t_rel, bsel, (t_rel / int'(G)) % 2);
      end
      checks++;
      if (dem !== exp_dem) begin
        errors++; $display("FAIL run_demux t=%0d got=%b want=%b", t_rel, dem, exp_dem);
      end
    end
  endtask

  task automatic test_single_spike_n2();
    logic [Q-1:0][N-1:0] want;
    do_clear();
    net_en = 2'b11;
    for (int t = 0; t < 3 * int'(G); t++) begin
      muxed = (t == 3) ? 2'b01 : 2'b00;
      step();
      want = ((t_rel / int'(G)) == 1 &&
              ((t_rel % int'(G)) == 7 || (t_rel % int'(G)) == 8)) ? 4'b0001 : 4'b0000;
      checks++;
      if (dem !== want) begin
        errors++; $display("FAIL single_n2 t=%0d got=%b want=%b", t_rel, dem, want);
      end
    end
  endtask

  task automatic test_single_spike_n3();
    logic [Q-1:0][2:0] want;
    do_clear();
    net_en3 = 3'b111;
    for (int t = 0; t < 3 * int'(G); t++) begin
      muxed = (t == 13) ? 2'b10 : 2'b00;
      step();
      want = ((t_rel / int'(G)) == 1 && (t_rel % int'(G)) >= 4 &&
              (t_rel % int'(G)) <= 6) ? 6'b100000 : 6'b000000;
      checks++;
      if (dem3 !== want) begin
        errors++; $display("FAIL single_n3 t=%0d got=%b want=%b", t_rel, dem3, want);
      end
    end
  endtask

  task automatic test_net_en();
    do_clear();
    net_en = 2'b11;
    for (int t = 0; t < 6 * int'(G); t++) begin
      if (t == int'(G) + 5)     net_en = 2'b01;
      if (t == 3 * int'(G) + 9) net_en = 2'b11;
      muxed = Q'($urandom);
      step();
      checks++;
      if (dem !== exp_dem) begin
        errors++; $display("FAIL net_en_demux t=%0d got=%b want=%b", t_rel, dem, exp_dem);
      end
      if ((t_rel / int'(G)) == 2 && (t_rel % int'(G)) != 0) begin
        checks++;
        if ((dem[0][1] | dem[1][1]) !== 1'b0) begin
          errors++; $display("FAIL net_en_forced t=%0d got=%b want=0", t_rel, dem);
        end
      end
    end
  endtask

  task automatic test_start_drop();
    do_clear();
    net_en = 2'b11;
    for (int t = 0; t < int'(G) + 10; t++) begin
      muxed = Q'($urandom);
      step();
    end
    start_count = 1'b0;
    step();
    checks++;
    if ({dem, cnt, bsel, wrap, valid} !== '0) begin
      errors++; $display("FAIL start_drop_clear got=%h want=0", {dem, cnt, bsel, wrap, valid});
    end
    start_count = 1'b1;
    for (int t = 0; t < 2 * int'(G); t++) begin
      muxed = Q'($urandom);
      step();
      checks++;
      if ({valid, cnt} !== {1'(t_rel >= int'(G)), 5'(t_rel % int'(G))}) begin
        errors++; $display("FAIL restart_count t=%0d got=%b/%0d", t_rel, valid, cnt);
      end
      checks++;
      if (dem !== exp_dem) begin
        errors++; $display("FAIL restart_demux t=%0d got=%b want=%b", t_rel, dem, exp_dem);
      end
    end
  endtask

  task automatic test_async_rst_random();
    do_clear();
    net_en = 2'b11;
    for (int t = 0; t < 2 * int'(G) + 7; t++) begin
      muxed = Q'($urandom);
      step();
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dem, cnt, bsel, valid} !== '0) begin
      errors++; $display("FAIL async_rst got=%h want=0", {dem, cnt, bsel, valid});
    end
    #1 rst = 1'b0;
    model_clear();
    for (int t = 0; t < 5 * int'(G); t++) begin
      muxed = Q'($urandom);
      if ($urandom_range(9) == 0) net_en = N'($urandom);
      step();
      checks++;
      if (dem !== exp_dem || valid !== (m_g >= 1)) begin
        errors++; $display("FAIL random_model t=%0d got=%b/%b want=%b/%b", t_rel, dem, valid, exp_dem, m_g >= 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_from_start();
    test_single_spike_n2();
    test_single_spike_n3();
    test_net_en();
    test_start_drop();
    test_async_rst_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
